lb_slave_pipe: RTL and testbench
================================

# lb_slave_pipe

Registered local-bus adapter between the marble_base local-bus master and the cryomodule simulator/controller slave on `lb_clk`. It decodes an address window, pipelines strobes, address and write data into the slave, and regenerates a read-valid strobe with a fixed, parameterised latency. It supports back-to-back reads and counts accesses that miss the window or violate protocol. Out-of-window reads return a fixed pattern, so the master never hangs.

## Interface
- `AW`, 24: master address width.
- `SAW`, 17: slave address width; the slave sees `m_addr[SAW-1:0]`.
- `WINDOW`, 0: required value of `m_addr[AW-1:SAW]` for an in-window access.
- `READ_LAT`, 3: slave latency in cycles from the `s_read` cycle to a valid `s_rdata`. Legal range 1..8.
- `MISS_DATA`, 32'hdeadf00d: data returned for out-of-window reads.

Ports:
- `lb_clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-high reset.
- `m_strobe`  in  1  master access qualifier, one cycle per transaction.
- `m_rd`  in  1  read request, valid with `m_strobe`.
- `m_write`  in  1  write request, valid with `m_strobe`.
- `m_addr`  in  AW  master address.
- `m_wdata`  in  32  master write data.
- `m_rdata`  out  32  read data returned to the master.
- `m_rd_valid`  out  1  one-cycle pulse; `m_rdata` is valid in that cycle.
- `s_addr`  out  SAW  registered slave address.
- `s_wdata`  out  32  registered slave write data.
- `s_write`  out  1  one-cycle slave write pulse.
- `s_read`  out  1  one-cycle slave read pulse.
- `s_rdata`  in  32  slave read data, valid `READ_LAT` cycles after `s_read`.
- `miss_count`  out  16  saturating count of out-of-window and protocol-error accesses.
- `miss_clear`  in  1  synchronous clear of `miss_count`.

## Operation
- Hit test: `hit = (m_addr[AW-1:SAW] == WINDOW)`.
- Stage 1 (the cycle after `m_strobe`) registers `s_addr` and `s_wdata` on every strobe, and asserts at most one of `s_read` or `s_write`:
  - Read, in window (`m_rd & hit`): `s_read`=1.
  - Write only, in window (`m_write & ~m_rd & hit`): `s_write`=1.
  - Out-of-window access: neither pulse; `miss_count` increments.
  - `m_rd & m_write` together: treated as a read, write suppressed, `miss_count` increments once. An out-of-window collision also increments once, not twice.
  - `m_strobe` with neither `m_rd` nor `m_write`: ignored, no count.
- Read tracking:
  - Each read, hit or miss, pushes a token into a valid/hit shift pipeline of depth `READ_LAT`+2.
  - On token exit, `m_rd_valid`=1 and `m_rdata` = registered `s_rdata` for a hit, `MISS_DATA` for a miss.
  - One read per cycle is accepted indefinitely. Reads return in order, with no stall and no backpressure.
- `m_rdata` holds its last value between valid pulses.
- `miss_count` saturates at 16'hffff.
- If `miss_clear` and an increment occur in the same cycle, clear wins and the result is 0.
- Writes never produce `m_rd_valid`.

## Timing
- Reset values: all outputs are 0, including `m_rdata`, `s_addr`, `s_wdata` and `miss_count`. The pipeline is emptied.
- Reset asserted mid-operation drops all in-flight reads; no `m_rd_valid` is issued for them after reset releases.
- Strobe in cycle T:
  - `s_read`/`s_write` in T+1.
  - The slave presents data in T+1+`READ_LAT`; this block registers it.
  - `m_rd_valid` in T+2+`READ_LAT`. Default total latency is 5 cycles.
- Miss reads follow the identical latency, so master timing is address-independent.
- `miss_count` updates in T+1.
- Strobes on consecutive cycles yield consecutive `m_rd_valid` pulses, each carrying its own data.

## Test plan
- Single read at `m_addr`=24'h000010 with the slave returning 32'h12345678 → `s_read` at T+1 with `s_addr`=17'h10; `m_rd_valid` with `m_rdata`=32'h12345678 at T+5.
- Write at 24'h01ffff with data 32'hcafe0001 → `s_write` at T+1 with `s_addr`=17'h1ffff and `s_wdata`=32'hcafe0001; no `m_rd_valid`; `miss_count` stays 0.
- Eight back-to-back reads at addresses 0..7, slave model returning addr+100 → eight consecutive `m_rd_valid` pulses starting at T+5 carrying 100..107 in order.
- Read at 24'h020000 (out of window) → no `s_read`; `m_rd_valid` at T+5 with 32'hdeadf00d; `miss_count`=1. A strobe with `m_rd`=`m_write`=1 in window → `s_read` only; `miss_count`=2.
- Saturation and clear: force 65537 misses → `miss_count`=16'hffff; `miss_clear` together with a miss → 0.
- Issue three reads, assert `rst` for one cycle two cycles later → no `m_rd_valid` ever appears; all outputs read 0 after reset.

Source files
------------

// File: rtl/lb_slave_pipe.sv
// Registered local-bus adapter: window decode, one-cycle strobe/addr/data stage into the slave,
// and a fixed-latency read-valid regeneration pipeline that also covers out-of-window reads.
module lb_slave_pipe #(
   parameter int          AW        = 24,
   parameter int          SAW       = 17,
   parameter int unsigned WINDOW    = 0,
   parameter int          READ_LAT  = 3,
   parameter logic [31:0] MISS_DATA = 32'hdeadf00d
) (
   input  logic           lb_clk,
   input  logic           rst,
   input  logic           m_strobe,
   input  logic           m_rd,
   input  logic           m_write,
   input  logic [AW-1:0]  m_addr,
   input  logic [31:0]    m_wdata,
   output logic [31:0]    m_rdata,
   output logic           m_rd_valid,
   output logic [SAW-1:0] s_addr,
   output logic [31:0]    s_wdata,
   output logic           s_write,
   output logic           s_read,
   input  logic [31:0]    s_rdata,
   output logic [15:0]    miss_count,
   input  logic           miss_clear
);

   localparam int STAGES = READ_LAT + 1;
   localparam logic [AW-SAW-1:0] WIN = WINDOW[AW-SAW-1:0];

   typedef struct packed {
      logic hit;
      logic rd;
      logic wr;
      logic miss;
   } req_t;

   req_t req;
   logic [STAGES:0]   vld_pipe;
   logic [READ_LAT:0] hit_pipe;

   // A read wins over a simultaneous write; the collision itself is what gets counted.
   always_comb begin
      req.hit  = (m_addr[AW-1:SAW] == WIN);
      req.rd   = m_strobe & m_rd;
      req.wr   = m_strobe & m_write & ~m_rd;
      req.miss = m_strobe & (m_rd | m_write) & (~req.hit | (m_rd & m_write));
   end

   assign m_rd_valid = vld_pipe[STAGES];

   always_ff @(posedge lb_clk or posedge rst) begin
      if (rst) begin
         s_addr     <= '0;
         s_wdata    <= '0;
         s_read     <= 1'b0;
         s_write    <= 1'b0;
         vld_pipe   <= '0;
         hit_pipe   <= '0;
         m_rdata    <= '0;
         miss_count <= '0;
      end else begin
         if (m_strobe) begin
            s_addr  <= m_addr[SAW-1:0];
            s_wdata <= m_wdata;
         end
         s_read   <= req.rd & req.hit;
         s_write  <= req.wr & req.hit;
         vld_pipe <= {vld_pipe[STAGES-1:0], req.rd};
         hit_pipe <= {hit_pipe[READ_LAT-1:0], req.hit};
         // Token sits at READ_LAT exactly when the slave's data is on s_rdata.
         if (vld_pipe[READ_LAT])
            m_rdata <= hit_pipe[READ_LAT] ? s_rdata : MISS_DATA;
         if (miss_clear)
            miss_count <= '0;
         else if (req.miss && miss_count != 16'hffff)
            miss_count <= miss_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_lb_slave_pipe.sv
// Randomized and directed bench for lb_slave_pipe against a cycle-indexed transaction model.
module tb_lb_slave_pipe;
   localparam int          AW = 24, SAW = 17, L = 3;
   localparam logic [31:0] MISS = 32'hdeadf00d;

   logic           lb_clk = 1'b0, rst = 1'b1;
   logic           m_strobe = 0, m_rd = 0, m_write = 0, miss_clear = 0;
   logic [AW-1:0]  m_addr = '0;
   logic [31:0]    m_wdata = '0, m_rdata, s_wdata, s_rdata;
   logic           m_rd_valid, s_write, s_read;
   logic [SAW-1:0] s_addr;
   logic [15:0]    miss_count;

   lb_slave_pipe #(.AW(AW), .SAW(SAW), .WINDOW(0), .READ_LAT(L), .MISS_DATA(MISS)) dut (
      .lb_clk(lb_clk), .rst(rst), .m_strobe(m_strobe), .m_rd(m_rd), .m_write(m_write),
      .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata), .m_rd_valid(m_rd_valid),
      .s_addr(s_addr), .s_wdata(s_wdata), .s_write(s_write), .s_read(s_read),
      .s_rdata(s_rdata), .miss_count(miss_count), .miss_clear(miss_clear));

   always #5 lb_clk = ~lb_clk;

   // Slave: data = address + sl_base, presented L cycles after s_read; junk otherwise.
   logic [31:0] sl_base = 32'd100;
   logic [31:0] dl [L];
   initial for (int i = 0; i < L; i++) dl[i] = '0;
   always @(posedge lb_clk) begin
      dl[0] <= s_read ? ({15'b0, s_addr} + sl_base) : $urandom();
      for (int i = 1; i < L; i++) dl[i] <= dl[i-1];
   end
   assign s_rdata = dl[L-1];

   typedef struct { int due; logic [31:0] data; } rd_t;
   rd_t          q[$];
   int           cyc = 0, n_chk = 0, n_err = 0;
   bit           do_chk = 1;
   logic         e_sread, e_swrite;
   logic [16:0]  e_saddr;
   logic [31:0]  e_swdata, e_rdata;
   logic [15:0]  e_cnt;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      e_sread = 0; e_swrite = 0; e_saddr = '0; e_swdata = '0; e_rdata = '0; e_cnt = '0;
   endtask

   // One cycle: compare outputs at the falling edge, then fold this cycle's inputs into the model.
   task automatic tick();
      bit vld, hitm, inc;
      @(negedge lb_clk);
      if (rst) model_reset();
      vld = (q.size() > 0) && (q[0].due == cyc);
      if (vld) begin e_rdata = q[0].data; void'(q.pop_front()); end
      if (do_chk) begin
         chk("m_rd_valid", {31'b0, m_rd_valid}, {31'b0, vld});
         chk("m_rdata", m_rdata, e_rdata);
         chk("s_read", {31'b0, s_read}, {31'b0, e_sread});
         chk("s_write", {31'b0, s_write}, {31'b0, e_swrite});
         chk("s_addr", {15'b0, s_addr}, {15'b0, e_saddr});
         chk("s_wdata", s_wdata, e_swdata);
         chk("miss_count", {16'b0, miss_count}, {16'b0, e_cnt});
      end
      if (!rst) begin
         e_sread = 0; e_swrite = 0; inc = 0;
         if (m_strobe) begin
            hitm = (m_addr[AW-1:SAW] == 0);
            e_saddr = m_addr[16:0]; e_swdata = m_wdata;
            if (m_rd) begin
               e_sread = hitm;
               q.push_back('{cyc + 2 + L, hitm ? ({15'b0, m_addr[16:0]} + sl_base) : MISS});
            end else if (m_write) e_swrite = hitm;
            inc = (m_rd || m_write) && (!hitm || (m_rd && m_write));
         end
         if (miss_clear) e_cnt = 0;
         else if (inc && e_cnt != 16'hffff) e_cnt = e_cnt + 1;
      end
      @(posedge lb_clk); #1;
      cyc++;
   endtask

   task automatic drive(input bit stb, input bit rd, input bit wr, input logic [23:0] a,
                        input logic [31:0] wd, input bit clr);
      m_strobe = stb; m_rd = rd; m_write = wr; m_addr = a; m_wdata = wd; miss_clear = clr;
      tick();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 24'h0, 32'h0, 0);
   endtask

   initial begin
      model_reset();
      tick(); tick();
      rst = 0;
      idle(2);
      // single read, slave answers 12345678
      sl_base = 32'h12345678 - 32'h10;
      drive(1, 1, 0, 24'h000010, 32'h0, 0);
      idle(8);
      sl_base = 32'd100;
      // in-window write at top of window
      drive(1, 0, 1, 24'h01ffff, 32'hcafe0001, 0);
      idle(8);
      // eight back-to-back reads
      for (int i = 0; i < 8; i++) drive(1, 1, 0, 24'(i), 32'h0, 0);
      idle(8);
      // out-of-window read, then in-window collision
      drive(1, 1, 0, 24'h020000, 32'h0, 0);
      idle(3);
      drive(1, 1, 1, 24'h000020, 32'h55aa55aa, 0);
      idle(8);
      // ignored strobe
      drive(1, 0, 0, 24'h7f0001, 32'h1111, 0);
      idle(2);
      // randomized traffic
      for (int i = 0; i < 500; i++) begin
         logic [23:0] a;
         a = ($urandom_range(3) == 0) ? 24'($urandom()) : {7'b0, 17'($urandom())};
         drive($urandom_range(9) < 7, $urandom_range(1) == 1, $urandom_range(1) == 1, a,
               $urandom(), $urandom_range(24) == 0);
      end
      idle(8);
      // reset with reads in flight
      drive(1, 1, 0, 24'h000004, 32'h0, 0);
      drive(1, 1, 0, 24'h020004, 32'h0, 0);
      drive(1, 1, 0, 24'h000005, 32'h0, 0);
      idle(2);
      rst = 1;
      idle(1);
      rst = 0;
      idle(10);
      // saturation: bulk out-of-window writes with per-cycle checks suppressed
      drive(0, 0, 0, 24'h0, 32'h0, 1);
      do_chk = 0;
      for (int i = 0; i < 65537; i++) drive(1, 0, 1, 24'h400000, 32'h0, 0);
      do_chk = 1;
      idle(2);
      drive(1, 0, 1, 24'h400000, 32'h0, 1);
      idle(3);
      if (q.size() != 0) chk("rd_drain", 32'(q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
